circuit_seq_ctrl: RTL and testbench
===================================

// Module: circuit_seq_ctrl
// PURPOSE
//  Frame sequencer for the circuit datapath (en/x in, wide y out). Accepts a start command with a
//  frame length, restarts the datapath, streams exactly LEN samples into it from a valid/ready
//  source and waits out the datapath latency. It then captures y and offers it on a valid/ready
//  result port. Sits between the sample source and the circuit instance.
// PARAMETERS
//  DATA_W   32   sample width (dp_x, in_data)
//  Y_W      100  datapath result width (dp_y, res_data)
//  LEN_W    16   frame-length width
//  DP_LAT   1    cycles from the last dp_en edge until dp_y is final (>=1)
//  TIMEOUT  1024 stall limit in cycles (used only with CIRCUIT_SEQ_CTRL_TIMEOUT_EN)
// PORTS
//  clk       in   1      clock, rising edge
//  rst       in   1      asynchronous reset, active-high
//  start     in   1      begin a frame; sampled only in IDLE
//  len       in   LEN_W  samples per frame; captured with start
//  in_valid  in   1      sample available
//  in_data   in   DATA_W sample
//  in_ready  out  1      sample accepted when in_valid&in_ready at posedge
//  dp_rst    out  1      synchronous restart pulse to the datapath
//  dp_en     out  1      datapath enable (one cycle per sample)
//  dp_x      out  DATA_W datapath sample
//  dp_y      in   Y_W    datapath result
//  res_valid out  1      result available, held until taken
//  res_data  out  Y_W    captured result
//  res_ready in   1      result consumer ready
//  busy      out  1      state != IDLE
//  err       out  1      frame ended by timeout (0 without the macro)
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready, dp_rst, dp_en, res_valid, busy, err = 0; dp_x, res_data, counters = 0.
//  - All outputs registered except in_ready = (state==RUN) and busy = (state!=IDLE).
//  - IDLE: start && len!=0 -> CLEAR, latch len. start with len==0 is ignored (stays IDLE, no result).
//  - CLEAR: dp_rst=1 for exactly 1 cycle; sample counter cleared; err cleared -> RUN.
//  - RUN: on accept, dp_en=1 and dp_x=in_data in the following cycle; otherwise dp_en=0 and dp_x holds.
//    On the accept with count==len-1 -> DRAIN (in_ready low from the next cycle). Max LEN = 2^LEN_W-1.
//  - DRAIN: wait DP_LAT+1 cycles after the last accept (1 for the dp_en register, DP_LAT for the
//    datapath); on the final cycle res_data<=dp_y, res_valid<=1 -> DONE.
//  - DONE: res_valid and res_data held stable; res_valid&&res_ready -> res_valid<=0, IDLE.
//    res_ready while res_valid=0 has no effect.
//  - start outside IDLE is ignored (no queueing). start and res_ready in the same DONE cycle:
//    only the handshake takes effect; start must be reissued in IDLE.
//  - rst asserted mid-frame aborts immediately: all outputs return to reset values; partial result lost.
//  - Sample counter and len compare are LEN_W-bit unsigned; no wrap (the exit is at len-1).
// CONFIGURATION
//  CIRCUIT_SEQ_CTRL_TIMEOUT_EN defined: a stall counter runs in RUN, clears on each accept and
//  increments otherwise. Reaching TIMEOUT -> DRAIN with err=1; the partial result is still captured
//  and delivered. err holds until the next CLEAR.
//  Undefined: no stall counter; RUN waits indefinitely; err tied 0.
// TESTING (bench stub datapath: y<=0 on dp_rst, y<=y+x on dp_en, DP_LAT=1)
//  1 len=3, samples 1,2,3, in_valid always 1, res_ready=1 -> one dp_rst, then dp_en for 3 cycles
//    with dp_x=1,2,3; res_valid one cycle with res_data=6; busy low the next cycle.
//  2 len=4, in_valid toggling 1,0,1,0..., samples 10,20,30,40 -> dp_en only on accepted cycles;
//    res_data=100.
//  3 res_ready=0 for 5 cycles after res_valid -> res_valid/res_data=stable for 5 cycles; start
//    pulses during frame and DONE ignored; busy stays 1 until the handshake.
//  4 start with len=0 -> busy stays 0, no dp_rst, no res_valid; then len=2 (7,8) -> res_data=15.
//  5 rst pulse after 2 of 5 samples -> all outputs 0 at once; new frame len=1 (5) -> res_data=5.
//  6 (TIMEOUT_EN, TIMEOUT=8) len=3, one sample (9), then in_valid=0 -> after 8 stall cycles:
//    err=1, res_data=9.

Source files
------------

// File: rtl/circuit_seq_ctrl.sv
// Frame sequencer: restarts the circuit datapath, streams LEN samples into it, waits out its latency
// and offers the captured result. Optional stall timeout enabled by CIRCUIT_SEQ_CTRL_TIMEOUT_EN.
module circuit_seq_ctrl #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned Y_W     = 100,
    parameter int unsigned LEN_W   = 16,
    parameter int unsigned DP_LAT  = 1,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dp_rst,
    output logic              dp_en,
    output logic [DATA_W-1:0] dp_x,
    input  logic [Y_W-1:0]    dp_y,
    output logic              res_valid,
    output logic [Y_W-1:0]    res_data,
    input  logic              res_ready,
    output logic              busy,
    output logic              err
);

    localparam int unsigned DRAIN_W = $clog2(DP_LAT + 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Reject parameter values the drain/timeout logic cannot honour.
    if (DP_LAT < 1 || TIMEOUT < 1) begin : g_param_check
        $error("circuit_seq_ctrl: DP_LAT and TIMEOUT must be >= 1");
    end

    state_e             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [DRAIN_W-1:0] drain_q, drain_d;
    logic               dp_rst_q, dp_rst_d;
    logic               dp_en_q, dp_en_d;
    logic [DATA_W-1:0]  dp_x_q, dp_x_d;
    logic               res_valid_q, res_valid_d;
    logic [Y_W-1:0]     res_data_q, res_data_d;
    logic               accept;

`ifdef CIRCUIT_SEQ_CTRL_TIMEOUT_EN
    localparam int unsigned STALL_W = $clog2(TIMEOUT) + 1;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;
`endif

    assign in_ready  = (state_q == ST_RUN);
    assign busy      = (state_q != ST_IDLE);
    assign accept    = in_valid && in_ready;
    assign dp_rst    = dp_rst_q;
    assign dp_en     = dp_en_q;
    assign dp_x      = dp_x_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
`ifdef CIRCUIT_SEQ_CTRL_TIMEOUT_EN
    assign err       = err_q;
`else
    assign err       = 1'b0;
`endif

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        drain_d     = drain_q;
        dp_rst_d    = 1'b0;
        dp_en_d     = 1'b0;
        dp_x_d      = dp_x_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
`ifdef CIRCUIT_SEQ_CTRL_TIMEOUT_EN
        stall_d     = stall_q;
        err_d       = err_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (start && (len != '0)) begin
                    state_d  = ST_CLEAR;
                    len_d    = len;
                    dp_rst_d = 1'b1;
                end
            end
            ST_CLEAR: begin
                cnt_d   = '0;
`ifdef CIRCUIT_SEQ_CTRL_TIMEOUT_EN
                stall_d = '0;
                err_d   = 1'b0;
`endif
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (accept) begin
                    dp_en_d = 1'b1;
                    dp_x_d  = in_data;
                    cnt_d   = cnt_q + LEN_W'(1);
`ifdef CIRCUIT_SEQ_CTRL_TIMEOUT_EN
                    stall_d = '0;
`endif
                    // Exit at len-1 so a maximal len never needs the counter to wrap.
                    if (cnt_q == (len_q - LEN_W'(1))) begin
                        state_d = ST_DRAIN;
                        drain_d = '0;
                    end
                end
`ifdef CIRCUIT_SEQ_CTRL_TIMEOUT_EN
                else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                    state_d = ST_DRAIN;
                    drain_d = '0;
                    err_d   = 1'b1;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
`endif
            end
            ST_DRAIN: begin
                // One cycle for the dp_en register plus DP_LAT for the datapath itself.
                if (drain_q == DRAIN_W'(DP_LAT)) begin
                    res_data_d  = dp_y;
                    res_valid_d = 1'b1;
                    state_d     = ST_DONE;
                end else begin
                    drain_d = drain_q + DRAIN_W'(1);
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    res_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            len_q       <= '0;
            cnt_q       <= '0;
            drain_q     <= '0;
            dp_rst_q    <= 1'b0;
            dp_en_q     <= 1'b0;
            dp_x_q      <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            drain_q     <= drain_d;
            dp_rst_q    <= dp_rst_d;
            dp_en_q     <= dp_en_d;
            dp_x_q      <= dp_x_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
        end
    end

`ifdef CIRCUIT_SEQ_CTRL_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            stall_q <= stall_d;
            err_q   <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_circuit_seq_ctrl.sv
// Directed bench for circuit_seq_ctrl with an accumulating stub datapath (y<=0 on dp_rst, y+=x on dp_en).
module tb_circuit_seq_ctrl;

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned Y_W     = 100;
    localparam int unsigned LEN_W   = 16;
    localparam int unsigned DP_LAT  = 1;
    localparam int unsigned TIMEOUT = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              dp_rst;
    logic              dp_en;
    logic [DATA_W-1:0] dp_x;
    logic [Y_W-1:0]    dp_y;
    logic              res_valid;
    logic [Y_W-1:0]    res_data;
    logic              res_ready;
    logic              busy;
    logic              err;

    int n_chk = 0;
    int n_bad = 0;
    int n_rst = 0;
    logic [DATA_W-1:0] en_q[$];
    logic [DATA_W-1:0] smp [8];

    circuit_seq_ctrl #(
        .DATA_W (DATA_W),
        .Y_W    (Y_W),
        .LEN_W  (LEN_W),
        .DP_LAT (DP_LAT),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .len      (len),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .dp_rst   (dp_rst),
        .dp_en    (dp_en),
        .dp_x     (dp_x),
        .dp_y     (dp_y),
        .res_valid(res_valid),
        .res_data (res_data),
        .res_ready(res_ready),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Stub datapath with one cycle of latency.
    always @(posedge clk) begin
        if (dp_rst)     dp_y <= '0;
        else if (dp_en) dp_y <= dp_y + Y_W'(dp_x);
    end

    // Record restart pulses and every sample handed to the datapath.
    always @(negedge clk) begin
        if (dp_rst) n_rst++;
        if (dp_en)  en_q.push_back(dp_x);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"},  128'(in_ready),  128'(0));
        chk({tag, "_dp_rst"},    128'(dp_rst),    128'(0));
        chk({tag, "_dp_en"},     128'(dp_en),     128'(0));
        chk({tag, "_dp_x"},      128'(dp_x),      128'(0));
        chk({tag, "_res_valid"}, 128'(res_valid), 128'(0));
        chk({tag, "_res_data"},  128'(res_data),  128'(0));
        chk({tag, "_busy"},      128'(busy),      128'(0));
        chk({tag, "_err"},       128'(err),       128'(0));
    endtask

    // Run one frame: n = len, nvalid = samples the source offers, toggle = valid every other cycle,
    // rr_delay = res_valid cycles before res_ready rises, spurious = extra start pulses while busy,
    // abort_after = return once that many samples were accepted (0 = run to completion).
    task automatic do_frame(input string tag, input int n, input int nvalid, input bit toggle,
                            input int rr_delay, input bit spurious, input int abort_after,
                            input logic [Y_W-1:0] exp_sum, input bit exp_err);
        int  k, rv, rst0, n_exp;
        bit  acc, hs, fin, ph;
        k = 0; rv = 0; fin = 1'b0; ph = 1'b0;
        en_q.delete();
        rst0  = n_rst;
        start = 1'b1;
        len   = LEN_W'(n);
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 80 && !fin; cyc++) begin
            in_valid  = (k < nvalid) && (!toggle || !ph);
            ph        = !ph;
            in_data   = smp[k];
            res_ready = (rv >= rr_delay);
            start     = spurious && ((cyc % 3 == 0) || (res_valid && res_ready));
            if (start) len = LEN_W'(5);
            if (spurious) chk({tag, "_busy_held"}, 128'(busy), 128'(1));
            if (res_valid) begin
                chk({tag, "_res_data"}, 128'(res_data), 128'(exp_sum));
                chk({tag, "_err"},      128'(err),      128'(exp_err));
                rv++;
            end
            acc = in_valid && in_ready;
            hs  = res_valid && res_ready;
            step();
            if (acc) k++;
            if (hs)  fin = 1'b1;
            if (abort_after != 0 && k == abort_after) return;
        end
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        n_exp = (nvalid < n) ? nvalid : n;
        chk({tag, "_finished"},   128'(fin),          128'(1));
        chk({tag, "_dp_rst_cnt"}, 128'(n_rst - rst0), 128'(1));
        chk({tag, "_dp_en_cnt"},  128'(en_q.size()),  128'(n_exp));
        for (int i = 0; i < n_exp && i < en_q.size(); i++)
            chk({tag, "_dp_x"}, 128'(en_q[i]), 128'(smp[i]));
        chk({tag, "_res_cycles"}, 128'(rv),   128'(rr_delay + 1));
        chk({tag, "_busy_after"}, 128'(busy), 128'(0));
        step();
        chk({tag, "_busy_idle"},  128'(busy), 128'(0));
        chk({tag, "_res_valid_idle"}, 128'(res_valid), 128'(0));
    endtask

    initial begin
        int rst0;
        rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0; in_data = '0; res_ready = 1'b0;
        for (int i = 0; i < 8; i++) smp[i] = '0;
        step(); step();
        chk_all_zero("reset");
        rst = 1'b0;
        step();
        chk_all_zero("post_reset");

        // 1: back-to-back samples, consumer always ready.
        smp[0] = 32'd1; smp[1] = 32'd2; smp[2] = 32'd3;
        do_frame("t1", 3, 3, 1'b0, 0, 1'b0, 0, Y_W'(6), 1'b0);

        // 2: source valid only every other cycle.
        smp[0] = 32'd10; smp[1] = 32'd20; smp[2] = 32'd30; smp[3] = 32'd40;
        do_frame("t2", 4, 4, 1'b1, 0, 1'b0, 0, Y_W'(100), 1'b0);

        // 3: consumer stalls 5 cycles; stray starts during the frame and in DONE.
        smp[0] = 32'd4; smp[1] = 32'd5;
        do_frame("t3", 2, 2, 1'b0, 5, 1'b1, 0, Y_W'(9), 1'b0);

        // 4: zero-length start is ignored.
        rst0  = n_rst;
        start = 1'b1; len = '0;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("t4_busy", 128'(busy), 128'(0));
            chk("t4_res_valid", 128'(res_valid), 128'(0));
            step();
        end
        chk("t4_no_dp_rst", 128'(n_rst - rst0), 128'(0));
        smp[0] = 32'd7; smp[1] = 32'd8;
        do_frame("t4", 2, 2, 1'b0, 0, 1'b0, 0, Y_W'(15), 1'b0);

        // 5: asynchronous reset after 2 of 5 samples, then a fresh single-sample frame.
        smp[0] = 32'd1; smp[1] = 32'd2; smp[2] = 32'd3; smp[3] = 32'd4; smp[4] = 32'd5;
        do_frame("t5a", 5, 5, 1'b0, 0, 1'b0, 2, Y_W'(0), 1'b0);
        chk("t5_dp_en_before_rst", 128'(dp_en), 128'(1));
        start = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        rst = 1'b1;
        #1;
        chk_all_zero("t5_abort");
        step();
        rst = 1'b0;
        step();
        smp[0] = 32'd5;
        do_frame("t5b", 1, 1, 1'b0, 0, 1'b0, 0, Y_W'(5), 1'b0);

`ifdef CIRCUIT_SEQ_CTRL_TIMEOUT_EN
        // 6: source dries up after one sample; stall timeout delivers the partial result.
        smp[0] = 32'd9;
        do_frame("t6", 3, 1, 1'b0, 0, 1'b0, 0, Y_W'(9), 1'b1);
        chk("t6_err_held", 128'(err), 128'(1));
        smp[0] = 32'd2;
        do_frame("t6b", 1, 1, 1'b0, 0, 1'b0, 0, Y_W'(2), 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
